alu_bank_arbiter: RTL and testbench

//  Shares one single-issue ALU core among NUM_BANKS requester banks using input_packet_t / output_packet_t.

---
 rtl/alu_bank_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_alu_bank_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bank_arbiter.sv
// Round-robin arbiter sharing one single-issue ALU core among NUM_BANKS request banks.
// Optional WAIT-state timeout is enabled by defining ALU_ARB_TIMEOUT_EN.
package alu_arb_pkg;
  typedef enum logic [1:0] {
    CMD_NOP      = 2'd0,
    CMD_ADD      = 2'd1,
    CMD_MULTIPLY = 2'd2,
    CMD_AND      = 2'd3
  } command_t;

  typedef enum logic [1:0] {
    RSP_NO_RESPONSE = 2'd0,
    RSP_SUCCESS     = 2'd1,
    RSP_OVERFLOW    = 2'd2
  } response_t;

  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
    command_t    command;
  } input_packet_t;

  typedef struct packed {
    response_t   response;
    logic [31:0] data;
  } output_packet_t;
endpackage

// Handshake: a bank request is any cycle with command!=NOP; a core op is the single
// cycle core_in.command!=NOP; the first core_out.response!=NO_RESPONSE seen in WAIT
// completes it; the result shows on bank_out[g] for exactly one cycle.
module alu_bank_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_BANKS      = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int GW            = $clog2(NUM_BANKS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  input_packet_t        bank_in [NUM_BANKS],
  output output_packet_t       bank_out [NUM_BANKS],
  output logic [NUM_BANKS-1:0] bank_busy,
  output logic [NUM_BANKS-1:0] bank_drop,
  output input_packet_t        core_in,
  input  output_packet_t       core_out,
  output logic [GW-1:0]        grant_id,
  output logic                 timeout_err
);
  localparam int SW = GW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t               state, state_d;
  input_packet_t        slot [NUM_BANKS];
  logic [GW-1:0]        rr_ptr;
  logic [NUM_BANKS-1:0] in_flight, eligible;
  logic [SW-1:0]        scan_idx;
  logic                 pick_valid;
  logic [GW-1:0]        pick;
  logic                 do_issue, do_deliver, timed_out;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`endif

  always_comb begin
    in_flight = '0;
    if (state == S_ISSUE || state == S_WAIT) in_flight[grant_id] = 1'b1;
    eligible = bank_busy & ~in_flight;
  end

  // Scan rr_ptr, rr_ptr+1, ... with explicit wrap so non-power-of-two counts work.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      scan_idx = {1'b0, rr_ptr} + SW'(k);
      if (scan_idx >= SW'(NUM_BANKS)) scan_idx = scan_idx - SW'(NUM_BANKS);
      if (!pick_valid && eligible[scan_idx[GW-1:0]]) begin
        pick_valid = 1'b1;
        pick       = scan_idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state;
    do_issue   = 1'b0;
    do_deliver = 1'b0;
    timed_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          do_issue = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (core_out.response != RSP_NO_RESPONSE) begin
          do_deliver = 1'b1;
          state_d    = S_DELIVER;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          do_deliver = 1'b1;
          timed_out  = 1'b1;
          state_d    = S_DELIVER;
        end
`endif
      end
      S_DELIVER: begin
        if (pick_valid) begin
          do_issue = 1'b1;
          state_d  = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      core_in   <= '0;
      grant_id  <= '0;
      bank_busy <= '0;
      bank_drop <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_out[i] <= '0;
        slot[i]     <= '0;
      end
    end else begin
      state <= state_d;
      // A request on the freeing edge still sees the slot busy and is dropped.
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_drop[i] <= (bank_in[i].command != CMD_NOP) && bank_busy[i];
        if (bank_in[i].command != CMD_NOP && !bank_busy[i]) begin
          slot[i]      <= bank_in[i];
          bank_busy[i] <= 1'b1;
        end
      end
      if (do_issue) begin
        core_in  <= slot[pick];
        grant_id <= pick;
        rr_ptr   <= (pick == GW'(NUM_BANKS - 1)) ? '0 : pick + 1'b1;
      end else begin
        core_in <= '0;
      end
      if (do_deliver) begin
        bank_out[grant_id]  <= timed_out ? '{response: RSP_OVERFLOW, data: 32'h0} : core_out;
        bank_busy[grant_id] <= 1'b0;
      end
      if (state == S_DELIVER) bank_out[grant_id] <= '0;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset || state != S_WAIT) wait_cnt <= '0;
    else wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) timeout_err <= 1'b0;
    else if (timed_out) timeout_err <= 1'b1;
  end
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_bank_arbiter.sv
// Bench for alu_bank_arbiter: 3-cycle core model, edge-level transaction model, literal pins.
// Timeout scenario runs only when ALU_ARB_TIMEOUT_EN is defined.
module tb_alu_bank_arbiter;
  import alu_arb_pkg::*;

  localparam int NB = 4;
  localparam int TO = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  input_packet_t  bank_in [NB];
  output_packet_t bank_out [NB];
  logic [NB-1:0]  bank_busy, bank_drop;
  input_packet_t  core_in;
  output_packet_t core_out;
  logic [1:0]     grant_id;
  logic           timeout_err;

  alu_bank_arbiter #(.NUM_BANKS(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .bank_in(bank_in), .bank_out(bank_out),
    .bank_busy(bank_busy), .bank_drop(bank_drop), .core_in(core_in),
    .core_out(core_out), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [37:0] exp_q[$];   // {bank[3:0], response, data} in delivery order
  int issue_log[$];
  int drop_cnt [NB];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- core model ----------------
  function automatic output_packet_t alu(input input_packet_t p);
    output_packet_t r;
    logic [32:0] s;
    logic [63:0] m;
    r = '0;
    case (p.command)
      CMD_ADD: begin
        s = {1'b0, p.data1} + {1'b0, p.data2};
        r.response = s[32] ? RSP_OVERFLOW : RSP_SUCCESS;
        r.data = s[31:0];
      end
      CMD_MULTIPLY: begin
        m = {32'h0, p.data1} * {32'h0, p.data2};
        r.response = (|m[63:32]) ? RSP_OVERFLOW : RSP_SUCCESS;
        r.data = m[31:0];
      end
      CMD_AND: begin
        r.response = RSP_SUCCESS;
        r.data = p.data1 & p.data2;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  bit             core_mute = 1'b0;
  int             core_cnt  = 0;
  output_packet_t core_resp;

  initial core_out = '0;

  always @(negedge clock) begin
    core_out = '0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) core_out = core_resp;
    end
    if (core_in.command != CMD_NOP && !core_mute) begin
      core_resp = alu(core_in);
      core_cnt  = 2;
    end
  end

  // ---------------- transaction model + compare ----------------
  logic [NB-1:0] m_busy = '0;
  input_packet_t m_slot [NB];
  int            m_rr = 0, m_g = 0, m_age = 0;
  bit            m_inflight = 1'b0, m_terr = 1'b0;

  always @(posedge clock) begin
    logic [NB-1:0]  cap, exp_drop;
    bit             deliver, issue;
    output_packet_t dval;
    int             g;
    #1;
    if (reset) begin
      check("rst_core_in", core_in, 0);
      for (int i = 0; i < NB; i++) check("rst_bank_out", bank_out[i], 0);
      check("rst_bank_busy", bank_busy, 0);
      check("rst_bank_drop", bank_drop, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_timeout_err", timeout_err, 0);
      m_busy = '0; m_inflight = 1'b0; m_rr = 0; m_g = 0; m_age = 0; m_terr = 1'b0;
    end else begin
      cap = '0; exp_drop = '0;
      deliver = 1'b0; issue = 1'b0; dval = '0; g = 0;
      for (int i = 0; i < NB; i++)
        if (bank_in[i].command != CMD_NOP) begin
          if (m_busy[i]) exp_drop[i] = 1'b1;
          else cap[i] = 1'b1;
        end
      if (m_inflight) begin
        m_age++;
        if (m_age >= 2 && core_out.response != RSP_NO_RESPONSE) begin
          deliver = 1'b1;
          dval = core_out;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (m_age == TO + 1) begin
          deliver = 1'b1;
          dval = '{response: RSP_OVERFLOW, data: 32'h0};
          m_terr = 1'b1;
        end
`endif
      end else begin
        for (int k = 0; k < NB; k++)
          if (!issue && m_busy[(m_rr + k) % NB]) begin
            issue = 1'b1;
            g = (m_rr + k) % NB;
          end
      end
      for (int i = 0; i < NB; i++)
        check("bank_out", bank_out[i], (deliver && i == m_g) ? dval : output_packet_t'('0));
      if (deliver) begin
        check("grant_at_deliver", grant_id, m_g);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL deliver_literal actual=%0h required=none", {4'(m_g), bank_out[m_g]});
        end else begin
          check("deliver_literal", {4'(m_g), bank_out[m_g]}, exp_q.pop_front());
        end
        m_busy[m_g] = 1'b0;
        m_inflight = 1'b0;
      end else if (m_inflight) begin
        check("grant_in_flight", grant_id, m_g);
      end
      if (issue) begin
        check("core_in_issue", core_in, m_slot[g]);
        check("grant_at_issue", grant_id, g);
        m_inflight = 1'b1; m_g = g; m_age = 0; m_rr = (g + 1) % NB;
        issue_log.push_back(g);
      end else begin
        check("core_in_idle", core_in.command, CMD_NOP);
      end
      for (int i = 0; i < NB; i++) begin
        if (cap[i]) begin
          m_busy[i] = 1'b1;
          m_slot[i] = bank_in[i];
        end
        drop_cnt[i] += int'(bank_drop[i]);
      end
      check("bank_busy", bank_busy, m_busy);
      check("bank_drop", bank_drop, exp_drop);
      check("timeout_err", timeout_err, m_terr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int b, input command_t c, input logic [31:0] a, input logic [31:0] d);
    bank_in[b] = '{data1: a, data2: d, command: c};
    @(negedge clock);
    bank_in[b] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int quiet = 0;
    for (int n = 0; n < 300 && quiet < 3; n++) begin
      @(negedge clock);
      if (bank_busy == '0 && !m_inflight) quiet++;
      else quiet = 0;
    end
    check(name, quiet, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d2;
    for (int i = 0; i < NB; i++) begin
      bank_in[i] = '0;
      drop_cnt[i] = 0;
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // single ADD on bank 0
    issue_log.delete();
    exp_q.push_back({4'd0, RSP_SUCCESS, 32'd12});
    send(0, CMD_ADD, 32'd5, 32'd7);
    wait_quiet("t1_quiet");
    check("t1_issue_count", issue_log.size(), 1);
    check("t1_issue_bank", issue_log[0], 0);

    // four banks on the same edge with rr_ptr=0
    do_reset();
    issue_log.delete();
    exp_q.push_back({4'd0, RSP_SUCCESS, 32'hF000_F000});
    exp_q.push_back({4'd1, RSP_SUCCESS, 32'd300});
    exp_q.push_back({4'd2, RSP_SUCCESS, 32'h0000_3000});
    exp_q.push_back({4'd3, RSP_SUCCESS, 32'hFFFF_FFFF});
    bank_in[0] = '{data1: 32'hF0F0_F0F0, data2: 32'hFF00_FF00, command: CMD_AND};
    bank_in[1] = '{data1: 32'd100, data2: 32'd200, command: CMD_ADD};
    bank_in[2] = '{data1: 32'd3, data2: 32'h1000, command: CMD_MULTIPLY};
    bank_in[3] = '{data1: 32'hFFFF_FFFE, data2: 32'd1, command: CMD_ADD};
    @(negedge clock);
    for (int i = 0; i < NB; i++) bank_in[i] = '0;
    wait_quiet("t2_quiet");
    check("t2_issue_count", issue_log.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_issue_order", issue_log[i], i);

    // rr_ptr wrapped back to 0: bank 0 wins over bank 1
    issue_log.delete();
    exp_q.push_back({4'd0, RSP_SUCCESS, 32'h0000_000F});
    exp_q.push_back({4'd1, RSP_SUCCESS, 32'd5});
    bank_in[1] = '{data1: 32'd2, data2: 32'd3, command: CMD_ADD};
    bank_in[0] = '{data1: 32'h0000_00FF, data2: 32'h0000_0F0F, command: CMD_AND};
    @(negedge clock);
    for (int i = 0; i < NB; i++) bank_in[i] = '0;
    wait_quiet("t2b_quiet");
    check("t2b_first", issue_log[0], 0);
    check("t2b_second", issue_log[1], 1);

    // second request on a busy bank is dropped
    issue_log.delete();
    d2 = drop_cnt[2];
    exp_q.push_back({4'd2, RSP_SUCCESS, 32'd30});
    send(2, CMD_ADD, 32'd10, 32'd20);
    send(2, CMD_MULTIPLY, 32'd4, 32'd4);
    wait_quiet("t3_quiet");
    check("t3_drop_pulses", drop_cnt[2] - d2, 1);
    check("t3_issue_count", issue_log.size(), 1);

    // reset while bank 1 waits on the core; late response must be ignored
    send(1, CMD_ADD, 32'd1, 32'd1);
    begin
      int n = 0;
      while (core_in.command == CMD_NOP && n < 20) begin
        @(negedge clock);
        n++;
      end
      check("t4_issue_seen", n < 20, 1);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t4_busy", bank_busy, 0);
    check("t4_core_in", core_in, 0);
    check("t4_grant", grant_id, 0);
    check("t4_bank_out1", bank_out[1], 0);
    reset = 1'b0;
    wait_quiet("t4_quiet");

    // overflow result, then back-to-back pending ops
    issue_log.delete();
    exp_q.push_back({4'd3, RSP_OVERFLOW, 32'h0});
    exp_q.push_back({4'd1, RSP_SUCCESS, 32'h0000_000F});
    exp_q.push_back({4'd2, RSP_OVERFLOW, 32'h0});
    send(3, CMD_ADD, 32'hFFFF_FFFF, 32'd1);
    bank_in[1] = '{data1: 32'h0000_00FF, data2: 32'h0000_000F, command: CMD_AND};
    bank_in[2] = '{data1: 32'h0001_0000, data2: 32'h0001_0000, command: CMD_MULTIPLY};
    @(negedge clock);
    for (int i = 0; i < NB; i++) bank_in[i] = '0;
    wait_quiet("t5_quiet");
    check("t5_issue_count", issue_log.size(), 3);
    check("t5_order0", issue_log[0], 3);
    check("t5_order1", issue_log[1], 1);
    check("t5_order2", issue_log[2], 2);

`ifdef ALU_ARB_TIMEOUT_EN
    // mute core: forced completion after TIMEOUT_CYCLES WAIT cycles
    core_mute = 1'b1;
    exp_q.push_back({4'd0, RSP_OVERFLOW, 32'h0});
    send(0, CMD_AND, 32'hFFFF_FFFF, 32'h1234_5678);
    wait_quiet("t6_quiet");
    repeat (4) @(negedge clock);
    check("t6_timeout_sticky", timeout_err, 1);
    core_mute = 1'b0;
    do_reset();
    check("t6_timeout_cleared", timeout_err, 0);
`else
    check("t6_timeout_tied", timeout_err, 0);
`endif

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
